regfile_mp_sb: RTL and testbench

- Parametrised multi-port general-purpose register file with a built-in pending-write scoreboard, the successor to the 2-read/1-write file.
- Serves the pipelined core. The decode stage reads N operands and learns per operand whether the value is usable. Issue marks destinations pending. Two writeback ports (ALU, load/MEM) retire results with same-cycle forwarding.
- Flush clears the scoreboard on branch/exception squash.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_mp_sb_if.sv | 37 +++
 rtl/regfile_fwd_mux.sv | 45 ++++
 rtl/regfile_mp_sb.sv | 109 ++++++++++
 tb/tb_regfile_mp_sb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// the hard-wired zero register index and the register address type.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the core pipeline (master) and the register file with
// scoreboard (slave): read ports, two writeback ports, issue and flush.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rrdy;

    logic                  we0;
    logic [ADDR_W-1:0]     waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  we1;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata1;

    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  flush;
    logic [ADDR_W:0]       pend_cnt;
    logic                  any_pend;

    modport master (
        output re, raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               iss_valid, iss_addr, flush,
        input  rdata, rrdy, pend_cnt, any_pend
    );

    modport slave (
        input  re, raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               iss_valid, iss_addr, flush,
        output rdata, rrdy, pend_cnt, any_pend
    );
endinterface : regfile_mp_sb_if

// File: rtl/regfile_fwd_mux.sv
// One read port: picks zero, a same-cycle writeback (port 1 over port 0)
// or the stored value, and derives whether the operand is usable.
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              rf_pend_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rrdy_o
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (raddr_i == ADDR_W'(REG_ZERO));

    always_comb begin
        rdata_o = '0;
        rrdy_o  = 1'b1;
        if (rst_i) begin
            rrdy_o = 1'b0;
        end else if (!re_i || is_zero) begin
            rrdy_o = 1'b1;
        end else if (we1_i && (waddr1_i == raddr_i)) begin
            rdata_o = wdata1_i;
        end else if (we0_i && (waddr0_i == raddr_i)) begin
            rdata_o = wdata0_i;
        end else begin
            rdata_o = rf_data_i;
            rrdy_o  = !rf_pend_i;
        end
    end

endmodule : regfile_fwd_mux

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard: NRD read ports with
// forwarding, two writeback ports, issue marking and flush.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_mp_sb_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   pend_cnt_q;
    logic [ADDR_W:0]   pend_cnt_d;
    logic              any_pend_q;
    logic              we0_eff;
    logic              we1_eff;

    assign we0_eff = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == ADDR_W'(REG_ZERO)));
    assign we1_eff = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == ADDR_W'(REG_ZERO)));

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            if (we0_eff) regs_q[bus.waddr0] <= bus.wdata0;
            if (we1_eff) regs_q[bus.waddr1] <= bus.wdata1;
        end
    end

    // A new issue beats a retiring write: the newer producer is still in flight.
    always_comb begin
        pend_d     = pend_q;
        pend_cnt_d = '0;
        if (bus.flush) begin
            pend_d = '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (bus.iss_valid && (bus.iss_addr == ADDR_W'(a)) &&
                    !((ZERO_REG != 0) && (a == REG_ZERO))) begin
                    pend_d[a] = 1'b1;
                end else if ((bus.we0 && (bus.waddr0 == ADDR_W'(a))) ||
                             (bus.we1 && (bus.waddr1 == ADDR_W'(a)))) begin
                    pend_d[a] = 1'b0;
                end
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[a]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
            any_pend_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            any_pend_q <= (pend_cnt_d != '0);
        end
    end

    assign bus.pend_cnt = pend_cnt_q;
    assign bus.any_pend = any_pend_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rf_data;
        logic              rf_pend;

        assign raddr   = bus.raddr[i*ADDR_W +: ADDR_W];
        assign rf_data = regs_q[raddr];
        assign rf_pend = pend_q[raddr];

        regfile_fwd_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_mux (
            .rst_i    (rst),
            .re_i     (bus.re[i]),
            .raddr_i  (raddr),
            .we0_i    (bus.we0),
            .waddr0_i (bus.waddr0),
            .wdata0_i (bus.wdata0),
            .we1_i    (bus.we1),
            .waddr1_i (bus.waddr1),
            .wdata1_i (bus.wdata1),
            .rf_data_i(rf_data),
            .rf_pend_i(rf_pend),
            .rdata_o  (bus.rdata[i*DATA_W +: DATA_W]),
            .rrdy_o   (bus.rrdy[i])
        );
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, forwarding, zero register,
// scoreboard set/clear, set-beats-clear and flush.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(N)) bus ();

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(N), .ZERO_REG(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.re        = '0;
        bus.raddr     = '0;
        bus.we0       = 1'b0;
        bus.waddr0    = '0;
        bus.wdata0    = '0;
        bus.we1       = 1'b0;
        bus.waddr1    = '0;
        bus.wdata1    = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_rd(input int p, input reg_addr_t a);
        bus.re[p]             = 1'b1;
        bus.raddr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return bus.rdata[p*DW +: DW];
    endfunction

    task automatic test_reset();
        logic [DW-1:0] got;
        for (int n = 1; n < 32; n++) begin
            bus.we0 = 1'b1; bus.waddr0 = AW'(n); bus.wdata0 = 32'hA5A5_0000 + n;
            tick();
        end
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
        tick();
        idle();
        set_rd(0, 5'd31);
        #1;
        n_checks++;
        if (rd(0) !== 32'hA5A5_001F) begin
            $display("FAIL pre_reset_r31: got %h want %h", rd(0), 32'hA5A5_001F); n_fail++;
        end
        n_checks++;
        if (bus.pend_cnt !== 6'd1) begin
            $display("FAIL pre_reset_pcnt: got %0d want 1", bus.pend_cnt); n_fail++;
        end
        // reset with a write and an issue in flight
        rst = 1'b1;
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hDEAD_BEEF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd20;
        set_rd(1, 5'd12);
        #1;
        n_checks++;
        if (bus.rrdy !== 2'b00 || bus.rdata !== '0) begin
            $display("FAIL during_rst: rrdy %b rdata %h want 00 / 0", bus.rrdy, bus.rdata); n_fail++;
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd0 || bus.any_pend !== 1'b0) begin
            $display("FAIL post_rst_pend: cnt %0d any %b want 0 0", bus.pend_cnt, bus.any_pend); n_fail++;
        end
        for (int n = 1; n < 32; n++) begin
            set_rd(0, AW'(n));
            #1;
            got = rd(0);
            n_checks++;
            if (got !== '0 || bus.rrdy[0] !== 1'b1) begin
                $display("FAIL post_rst_r%0d: got %h rdy %b want 0 1", n, got, bus.rrdy[0]); n_fail++;
            end
        end
        idle();
    endtask

    task automatic test_forward();
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h11;
        bus.we1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h22;
        set_rd(0, 5'd3);
        #1;
        n_checks++;
        if (rd(0) !== 32'h22 || bus.rrdy[0] !== 1'b1) begin
            $display("FAIL fwd_prio: got %h rdy %b want 22 1", rd(0), bus.rrdy[0]); n_fail++;
        end
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'h1234;
        bus.we1 = 1'b0;
        set_rd(1, 5'd10);
        #1;
        n_checks++;
        if (rd(0) !== 32'h22) begin
            $display("FAIL stored_r3: got %h want 22", rd(0)); n_fail++;
        end
        n_checks++;
        if (rd(1) !== 32'h1234 || bus.rrdy[1] !== 1'b1) begin
            $display("FAIL fwd_p0: got %h rdy %b want 1234 1", rd(1), bus.rrdy[1]); n_fail++;
        end
        tick();
        idle();
        bus.raddr = {5'd10, 5'd3};
        #1;
        n_checks++;
        if (bus.rdata !== '0 || bus.rrdy !== 2'b11) begin
            $display("FAIL re_off: rdata %h rrdy %b want 0 11", bus.rdata, bus.rrdy); n_fail++;
        end
        set_rd(1, 5'd10);
        #1;
        n_checks++;
        if (rd(1) !== 32'h1234) begin
            $display("FAIL stored_r10: got %h want 1234", rd(1)); n_fail++;
        end
        idle();
    endtask

    task automatic test_zero();
        bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF_FFFF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        n_checks++;
        if (rd(0) !== '0 || bus.rrdy[0] !== 1'b1) begin
            $display("FAIL zero_same: got %h rdy %b want 0 1", rd(0), bus.rrdy[0]); n_fail++;
        end
        tick();
        bus.we0 = 1'b0; bus.iss_valid = 1'b0;
        #1;
        n_checks++;
        if (rd(0) !== '0 || bus.rrdy[0] !== 1'b1 || bus.pend_cnt !== 6'd0) begin
            $display("FAIL zero_next: got %h rdy %b cnt %0d want 0 1 0", rd(0), bus.rrdy[0], bus.pend_cnt); n_fail++;
        end
        idle();
    endtask

    task automatic test_scoreboard();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        tick();
        idle();
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
        #1;
        n_checks++;
        if (bus.rrdy !== 2'b00 || bus.pend_cnt !== 6'd1 || bus.any_pend !== 1'b1) begin
            $display("FAIL sb_pending: rrdy %b cnt %0d any %b want 00 1 1", bus.rrdy, bus.pend_cnt, bus.any_pend); n_fail++;
        end
        bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h55;
        #1;
        n_checks++;
        if (rd(0) !== 32'h55 || bus.rrdy[0] !== 1'b1) begin
            $display("FAIL sb_fwd: got %h rdy %b want 55 1", rd(0), bus.rrdy[0]); n_fail++;
        end
        tick();
        bus.we1 = 1'b0;
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd0 || bus.any_pend !== 1'b0 || bus.rrdy[1] !== 1'b1 || rd(1) !== 32'h55) begin
            $display("FAIL sb_clear: cnt %0d any %b rdy %b data %h want 0 0 1 55",
                     bus.pend_cnt, bus.any_pend, bus.rrdy[1], rd(1)); n_fail++;
        end
        idle();
    endtask

    task automatic test_set_beats_clear();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        tick();
        bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h99;
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd1 || bus.rrdy[0] !== 1'b0 || rd(0) !== 32'h99) begin
            $display("FAIL set_beats_clr: cnt %0d rdy %b data %h want 1 0 99", bus.pend_cnt, bus.rrdy[0], rd(0)); n_fail++;
        end
        // retire 9 while issuing 2: count stays at one
        bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h9A;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd2;
        tick();
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd2);
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd1 || bus.rrdy !== 2'b01 || rd(0) !== 32'h9A) begin
            $display("FAIL swap_pend: cnt %0d rrdy %b data %h want 1 01 9a", bus.pend_cnt, bus.rrdy, rd(0)); n_fail++;
        end
        bus.we0 = 1'b1; bus.waddr0 = 5'd2; bus.wdata0 = 32'h2;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd0) begin
            $display("FAIL tidy: cnt %0d want 0", bus.pend_cnt); n_fail++;
        end
    endtask

    task automatic test_flush();
        for (int a = 4; a <= 6; a++) begin
            bus.iss_valid = 1'b1; bus.iss_addr = AW'(a);
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd3 || bus.any_pend !== 1'b1) begin
            $display("FAIL flush_pre: cnt %0d any %b want 3 1", bus.pend_cnt, bus.any_pend); n_fail++;
        end
        bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_addr = 5'd8;
        tick();
        idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd8);
        #1;
        n_checks++;
        if (bus.pend_cnt !== 6'd0 || bus.any_pend !== 1'b0 || bus.rrdy !== 2'b11) begin
            $display("FAIL flush_post: cnt %0d any %b rrdy %b want 0 0 11", bus.pend_cnt, bus.any_pend, bus.rrdy); n_fail++;
        end
        set_rd(1, 5'd6);
        #1;
        n_checks++;
        if (bus.rrdy[1] !== 1'b1) begin
            $display("FAIL flush_r6: rdy %b want 1", bus.rrdy[1]); n_fail++;
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_forward();
        test_zero();
        test_scoreboard();
        test_set_beats_clear();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp_sb
